multiport_rename_register_file: RTL and testbench

Parametrised architectural register file with ROB rename tags for the out-of-order core. It generalises the single-commit, single-update, two-read register file to multiple read ports, multiple commit ports and multiple rename (update) ports, so it supports superscalar dispatch and retirement. It adds intra-port priority, commit-to-read bypass, a hardwired-zero x0 and a live rename counter. It sits between dispatch (rename/operand read) and the ROB commit stage.

---
 rtl/mprf_pkg.sv | 15 +
 rtl/multiport_rename_register_file_rf_port_select.sv | 45 ++++
 rtl/multiport_rename_register_file.sv | 128 ++++++++++++
 tb/tb_multiport_rename_register_file.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mprf_pkg.sv
// Shared definitions for the multiport rename register file.
package mprf_pkg;

  localparam int RF_INDEX_WIDTH = 5;
  localparam int NUM_REGS = 2 ** RF_INDEX_WIDTH;

  function automatic int port_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/multiport_rename_register_file_rf_port_select.sv
// Per-entry priority encoder for the commit and update ports.
module rf_port_select
  import mprf_pkg::*;
#(
  parameter int NUM_WRITE = 2,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int INDEX = 1,
  parameter int PW = 1
) (
  input  logic [NUM_WRITE-1:0]                 commit_enable,
  input  logic [NUM_WRITE*REG_INDEX_WIDTH-1:0] commit_sel,
  input  logic [NUM_WRITE-1:0]                 update_enable,
  input  logic [NUM_WRITE*REG_INDEX_WIDTH-1:0] update_dest_reg,
  output logic                                 commit_hit,
  output logic [PW-1:0]                        commit_port,
  output logic                                 update_hit,
  output logic [PW-1:0]                        update_port
);

  localparam logic [REG_INDEX_WIDTH-1:0] ME =
    REG_INDEX_WIDTH'(INDEX);

  // Ascending scan: the youngest (highest) matching port wins.
  always_comb begin
    commit_hit  = 1'b0;
    commit_port = '0;
    update_hit  = 1'b0;
    update_port = '0;
    if (INDEX != 0) begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (commit_enable[k] &&
            commit_sel[lo(k, REG_INDEX_WIDTH) +: REG_INDEX_WIDTH] == ME) begin
          commit_hit  = 1'b1;
          commit_port = PW'(k);
        end
        if (update_enable[k] &&
            update_dest_reg[lo(k, REG_INDEX_WIDTH) +: REG_INDEX_WIDTH] == ME) begin
          update_hit  = 1'b1;
          update_port = PW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/multiport_rename_register_file.sv
// Multi-read, multi-commit, multi-rename register file with ROB tags.
module multiport_rename_register_file
  import mprf_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int ROB_INDEX_WIDTH = 8,
  parameter int NUM_READ = 4,
  parameter int NUM_WRITE = 2,
  parameter int BYPASS = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_WRITE-1:0]                 commit_enable,
  input  logic [NUM_WRITE*REG_INDEX_WIDTH-1:0] commit_sel,
  input  logic [NUM_WRITE*XLEN-1:0]            commit_data,
  input  logic [NUM_WRITE*ROB_INDEX_WIDTH-1:0] commit_ROB_index,
  input  logic [NUM_WRITE-1:0]                 update_enable,
  input  logic [NUM_WRITE*REG_INDEX_WIDTH-1:0] update_dest_reg,
  input  logic [NUM_WRITE*ROB_INDEX_WIDTH-1:0] update_ROB_index,
  input  logic [NUM_READ*REG_INDEX_WIDTH-1:0]  read_sel,
  output logic [NUM_READ*XLEN-1:0]             read_data,
  output logic [NUM_READ*ROB_INDEX_WIDTH-1:0] read_ROB,
  output logic [NUM_READ-1:0]                  read_ROB_is_renamed,
  output logic [REG_INDEX_WIDTH:0]             num_renamed
);

  localparam int NREG = 2 ** REG_INDEX_WIDTH;
  localparam int PW = port_width(NUM_WRITE);
  localparam int W = REG_INDEX_WIDTH;
  localparam int T = ROB_INDEX_WIDTH;

  logic [XLEN-1:0] data_a [NREG];
  logic [T-1:0]    tag_a  [NREG];
  logic [NREG-1:0] ren_a;

  for (genvar e = 0; e < NREG; e++) begin : g_ent
    logic          c_hit, u_hit;
    logic [PW-1:0] c_port, u_port;
    logic [XLEN-1:0] d_q;
    logic [T-1:0]    t_q;
    logic            r_q;
    logic            c_match;

    rf_port_select #(
      .NUM_WRITE(NUM_WRITE),
      .REG_INDEX_WIDTH(W),
      .INDEX(e),
      .PW(PW)
    ) u_sel (
      .commit_enable(commit_enable),
      .commit_sel(commit_sel),
      .update_enable(update_enable),
      .update_dest_reg(update_dest_reg),
      .commit_hit(c_hit),
      .commit_port(c_port),
      .update_hit(u_hit),
      .update_port(u_port)
    );

    assign c_match = c_hit && r_q &&
      (commit_ROB_index[int'(c_port) * T +: T] == t_q);

    // Flush beats update, update beats a commit's tag-match clear.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        d_q <= '0;
        t_q <= '0;
        r_q <= 1'b0;
      end else begin
        if (c_hit)
          d_q <= commit_data[int'(c_port) * XLEN +: XLEN];
        if (flush) begin
          r_q <= 1'b0;
        end else if (u_hit) begin
          r_q <= 1'b1;
          t_q <= update_ROB_index[int'(u_port) * T +: T];
        end else if (c_match) begin
          r_q <= 1'b0;
        end
      end
    end

    assign data_a[e] = d_q;
    assign tag_a[e]  = t_q;
    assign ren_a[e]  = r_q;
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [W-1:0]    s;
    logic            byp;
    logic [XLEN-1:0] bdata;
    logic [T-1:0]    btag;
    logic [XLEN-1:0] rd;
    logic            rn;

    assign s = read_sel[r*W +: W];

    always_comb begin
      byp   = 1'b0;
      bdata = '0;
      btag  = '0;
      if (BYPASS != 0 && s != '0) begin
        for (int k = 0; k < NUM_WRITE; k++) begin
          if (commit_enable[k] && commit_sel[lo(k, W) +: W] == s) begin
            byp   = 1'b1;
            bdata = commit_data[lo(k, XLEN) +: XLEN];
            btag  = commit_ROB_index[lo(k, T) +: T];
          end
        end
      end
      rd = byp ? bdata : data_a[s];
      rn = ren_a[s] && !(byp && btag == tag_a[s]);
    end

    assign read_data[r*XLEN +: XLEN] = rd;
    assign read_ROB[r*T +: T]        = tag_a[s];
    assign read_ROB_is_renamed[r]    = rn;
  end

  always_comb begin
    num_renamed = '0;
    for (int e = 0; e < NREG; e++)
      num_renamed = num_renamed + (W+1)'(ren_a[e]);
  end

endmodule

// File: tb/tb_multiport_rename_register_file.sv
// Directed self-checking bench for the multiport rename register file.
module tb_multiport_rename_register_file;
  import mprf_pkg::*;

  localparam int XL = 32;
  localparam int W = 5;
  localparam int T = 8;
  localparam int NR = 4;
  localparam int NW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush;
  logic [NW-1:0]    commit_enable;
  logic [NW*W-1:0]  commit_sel;
  logic [NW*XL-1:0] commit_data;
  logic [NW*T-1:0]  commit_ROB_index;
  logic [NW-1:0]    update_enable;
  logic [NW*W-1:0]  update_dest_reg;
  logic [NW*T-1:0]  update_ROB_index;
  logic [NR*W-1:0]  read_sel;
  logic [NR*XL-1:0] read_data;
  logic [NR*T-1:0]  read_ROB;
  logic [NR-1:0]    read_ROB_is_renamed;
  logic [W:0]       num_renamed;

  int compared = 0;
  int mismatched = 0;

  multiport_rename_register_file dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .commit_enable(commit_enable),
    .commit_sel(commit_sel),
    .commit_data(commit_data),
    .commit_ROB_index(commit_ROB_index),
    .update_enable(update_enable),
    .update_dest_reg(update_dest_reg),
    .update_ROB_index(update_ROB_index),
    .read_sel(read_sel),
    .read_data(read_data),
    .read_ROB(read_ROB),
    .read_ROB_is_renamed(read_ROB_is_renamed),
    .num_renamed(num_renamed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    commit_enable = '0;
    commit_sel = '0;
    commit_data = '0;
    commit_ROB_index = '0;
    update_enable = '0;
    update_dest_reg = '0;
    update_ROB_index = '0;
  endtask

  task automatic cm(input int p, input int r, input int d, input int t);
    commit_enable[p] = 1'b1;
    commit_sel[p*W +: W] = W'(r);
    commit_data[p*XL +: XL] = XL'(d);
    commit_ROB_index[p*T +: T] = T'(t);
  endtask

  task automatic up(input int p, input int r, input int t);
    update_enable[p] = 1'b1;
    update_dest_reg[p*W +: W] = W'(r);
    update_ROB_index[p*T +: T] = T'(t);
  endtask

  task automatic rd(input int p, input int r);
    read_sel[p*W +: W] = W'(r);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] dat(input int p);
    return read_data[p*XL +: XL];
  endfunction

  function automatic logic [31:0] tg(input int p);
    return 32'(read_ROB[p*T +: T]);
  endfunction

  function automatic logic [31:0] rn(input int p);
    return 32'(read_ROB_is_renamed[p]);
  endfunction

  function automatic logic [31:0] nr();
    return 32'(num_renamed);
  endfunction

  initial begin
    idle();
    read_sel = '0;
    #12;
    for (int i = 0; i < NUM_REGS; i += NR) begin
      for (int p = 0; p < NR; p++) rd(p, i + p);
      #1;
      for (int p = 0; p < NR; p++) begin
        chk("rst_data", dat(p), 0);
        chk("rst_ren", rn(p), 0);
      end
    end
    chk("rst_num", nr(), 0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    up(0, 1, 1); up(1, 2, 4);
    tick(); idle();
    rd(0, 1); rd(1, 2); #1;
    chk("upd_tag_r1", tg(0), 1);
    chk("upd_tag_r2", tg(1), 4);
    chk("upd_ren_r1", rn(0), 1);
    chk("upd_ren_r2", rn(1), 1);
    chk("upd_num", nr(), 2);

    cm(0, 1, 15, 5);
    tick(); idle(); #1;
    chk("cm_mis_data", dat(0), 15);
    chk("cm_mis_ren", rn(0), 1);

    cm(0, 2, 30, 4);
    tick(); idle(); #1;
    chk("cm_hit_data", dat(1), 30);
    chk("cm_hit_ren", rn(1), 0);
    chk("cm_hit_num", nr(), 1);

    cm(0, 3, 40, 0); cm(1, 3, 50, 0);
    tick(); idle();
    rd(2, 3); #1;
    chk("cm_prio", dat(2), 50);

    up(0, 3, 9); cm(0, 3, 50, 7);
    up(1, 6, 10);
    tick(); idle();
    up(0, 6, 10); up(1, 6, 11);
    tick(); idle();
    rd(3, 6); #1;
    chk("uc_data", dat(2), 50);
    chk("uc_tag", tg(2), 9);
    chk("uc_ren", rn(2), 1);
    chk("up_prio_tag", tg(3), 11);
    chk("uc_num", nr(), 3);

    rd(0, 5); cm(0, 5, 60, 0); cm(1, 5, 77, 0); #1;
    chk("byp_data", dat(0), 77);
    tick(); idle(); #1;
    chk("byp_stored", dat(0), 77);

    rd(2, 3); cm(0, 3, 88, 9); #1;
    chk("byp_r3_data", dat(2), 88);
    chk("byp_r3_ren", rn(2), 0);
    chk("byp_r3_tag", tg(2), 9);
    tick(); idle(); #1;
    chk("byp_r3_ren_q", rn(2), 0);
    chk("byp_num", nr(), 2);

    rd(0, 0); cm(0, 0, 99, 0); up(1, 0, 3); #1;
    chk("r0_byp", dat(0), 0);
    tick(); idle(); #1;
    chk("r0_data", dat(0), 0);
    chk("r0_tag", tg(0), 0);
    chk("r0_ren", rn(0), 0);
    chk("r0_num", nr(), 2);

    up(0, 2, 20); up(1, 3, 21);
    tick(); idle(); #1;
    chk("pre_fl_num", nr(), 4);
    flush = 1'b1; up(0, 4, 22);
    tick(); idle();
    rd(0, 4); rd(1, 2); #1;
    chk("fl_num", nr(), 0);
    chk("fl_r4_ren", rn(0), 0);
    chk("fl_r4_tag", tg(0), 0);
    chk("fl_r2_tag", tg(1), 20);
    chk("fl_r2_ren", rn(1), 0);

    up(0, 7, 5); cm(1, 8, 123, 0);
    tick(); idle();
    rd(0, 7); rd(1, 8); #1;
    chk("pre_rst_num", nr(), 1);
    chk("pre_rst_r8", dat(1), 123);
    flush = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_r8", dat(1), 0);
    chk("mid_rst_r7_ren", rn(0), 0);
    chk("mid_rst_r7_tag", tg(0), 0);
    chk("mid_rst_num", nr(), 0);
    idle();
    @(negedge clock);
    reset = 1'b1;
    tick(); #1;
    chk("post_rst_r8", dat(1), 0);
    chk("post_rst_num", nr(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
